pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register for the WISC pipeline: the general replacement for the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches. Carries an opaque data payload plus a control-bit field under a valid/ready handshake. A two-entry skid (main + skid) sustains full throughput with a registered `in_ready`. Adds synchronous flush, bubble insertion with control-field clearing, and a saturating back-pressure counter.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_stage_entry.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the WISC elastic pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_t;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 16;

  // Per-stage widths for the classic five-stage latches.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 8;
  localparam int EXMEM_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 3;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_BUSY: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of the elastic stage: valid flag plus payload and control bits.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              kill,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  // Kill only drops the valid flag so the payload lines stay quiet.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with a two-entry skid, flush,
// bubble control-clearing and a saturating back-pressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stat_clr
);

  pipe_state_t state_d, state_q;

  logic              accept, pop;
  logic              main_load, main_kill, main_sel_skid;
  logic              skid_load, skid_kill;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Next-state and entry steering; flush overrides whatever the handshake wanted.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_kill     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_kill     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_BUSY;
          main_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d   = ST_EMPTY;
          main_kill = 1'b1;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d       = ST_BUSY;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_kill     = 1'b1;
        end
      end
      default: begin
        state_d   = ST_EMPTY;
        main_kill = 1'b1;
        skid_kill = 1'b1;
      end
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_kill = 1'b1;
      skid_kill = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_in_data = main_sel_skid ? skid_data : in_data;
  assign main_in_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;

  pipe_stage_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .load    (main_load),
    .kill    (main_kill),
    .in_data (main_in_data),
    .in_ctrl (main_in_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_stage_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .load    (skid_load),
    .kill    (skid_kill),
    .in_data (in_data),
    .in_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  // Saturating stall counter; a clear request beats the increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = state_occupancy(state_q);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic          stat_clr;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] mData[$];
  logic [CW-1:0] mCtrl[$];
  logic [DW-1:0] mLast;
  int            mCnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stat_clr  (stat_clr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model's view of the held beats.
  task automatic checkAll(input string tag);
    int sz;
    sz = mData.size();
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(sz > 0));
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(sz < 2));
    checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(sz));
    checkOutput({tag, ".out_data"}, 64'(out_data), (sz > 0) ? 64'(mData[0]) : 64'(mLast));
    checkOutput({tag, ".out_ctrl"}, 64'(out_ctrl), (sz > 0) ? 64'(mCtrl[0]) : 64'd0);
    checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(mCnt));
  endtask

  task automatic modelReset();
    mData.delete();
    mCtrl.delete();
    mLast = '0;
    mCnt  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl, input logic clr, input string tag);
    int sz;
    bit acc;
    bit pp;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stat_clr  = clr;
    sz  = mData.size();
    acc = iv && (sz < 2);
    pp  = (sz > 0) && ordy;
    if (clr) mCnt = 0;
    else if ((sz > 0) && !ordy && (mCnt < CNT_MAX)) mCnt++;
    if (fl) begin
      mData.delete();
      mCtrl.delete();
    end else begin
      if (pp) begin
        void'(mData.pop_front());
        void'(mCtrl.pop_front());
      end
      if (acc) begin
        mData.push_back(d);
        mCtrl.push_back(c);
      end
    end
    if (mData.size() > 0) mLast = mData[0];
    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic idle(input logic ordy, input string tag);
    applyStimulus(1'b0, 64'hDEAD_BEEF_0000_0000, 8'h5A, ordy, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst = 1'b1;
    @(negedge clk);
    checkAll("postReset");

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 64'(i), 8'hFF, 1'b1, 1'b0, 1'b0, "stream");
      checkOutput("streamData", out_data, 64'(i));
      checkOutput("streamOcc", 64'(occupancy), 64'd1);
    end
    idle(1'b1, "bubble");
    checkOutput("bubbleCtrl", 64'(out_ctrl), 64'd0);
    checkOutput("bubbleData", out_data, 64'h8);

    // Back-pressure into the skid and release.
    applyStimulus(1'b1, 64'hA, 8'h11, 1'b0, 1'b0, 1'b0, "bpA");
    applyStimulus(1'b1, 64'hB, 8'h22, 1'b0, 1'b0, 1'b0, "bpB");
    checkOutput("bpInReady", 64'(in_ready), 64'd0);
    checkOutput("bpOcc", 64'(occupancy), 64'd2);
    applyStimulus(1'b1, 64'hC, 8'h33, 1'b0, 1'b0, 1'b0, "bpHold1");
    applyStimulus(1'b1, 64'hC, 8'h33, 1'b0, 1'b0, 1'b0, "bpHold2");
    checkOutput("bpStallCnt", 64'(stall_cnt), 64'd3);
    idle(1'b1, "bpRel1");
    checkOutput("bpRelB", out_data, 64'hB);
    idle(1'b1, "bpRel2");
    checkOutput("bpRelEmpty", 64'(out_valid), 64'd0);

    // Flush while full with an input beat offered.
    applyStimulus(1'b1, 64'h11, 8'hF1, 1'b0, 1'b0, 1'b1, "flA");
    applyStimulus(1'b1, 64'h22, 8'hF2, 1'b0, 1'b0, 1'b0, "flB");
    applyStimulus(1'b1, 64'h33, 8'hF3, 1'b0, 1'b1, 1'b0, "flush");
    checkOutput("flushValid", 64'(out_valid), 64'd0);
    checkOutput("flushCtrl", 64'(out_ctrl), 64'd0);
    checkOutput("flushOcc", 64'(occupancy), 64'd0);
    checkOutput("flushReady", 64'(in_ready), 64'd1);
    repeat (3) idle(1'b1, "postFlush");

    // Counter saturation and clear.
    applyStimulus(1'b1, 64'h77, 8'h07, 1'b0, 1'b0, 1'b1, "cntLoad");
    repeat (20) idle(1'b0, "cntStall");
    checkOutput("cntSat", 64'(stall_cnt), 64'hF);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "cntClr");
    checkOutput("cntClrVal", 64'(stall_cnt), 64'd0);
    idle(1'b1, "cntDrain");

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 3) != 0, rd, 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0, "rand");
    end

    // Asynchronous reset while full.
    applyStimulus(1'b1, 64'hE1, 8'hE1, 1'b0, 1'b0, 1'b0, "arFill1");
    applyStimulus(1'b1, 64'hE2, 8'hE2, 1'b0, 1'b0, 1'b0, "arFill2");
    applyStimulus(1'b1, 64'hE3, 8'hE3, 1'b0, 1'b0, 1'b0, "arFill3");
    checkOutput("arFullOcc", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkAll("asyncRst");
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAll("arRelease");
    repeat (3) idle(1'b1, "arNoStale");
    applyStimulus(1'b1, 64'h99, 8'h09, 1'b1, 1'b0, 1'b0, "arResume");
    checkOutput("arResumeData", out_data, 64'h99);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
